// File: rtl/note_sequence_player.sv
// note_sequence_player
//   Stores a sequence of up to DEPTH notes, plays it on the piezo with
//   programmable tone/gap durations, and checks player answers note-by-note,
//   echoing each answer on the piezo.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   load_en, load_data,   : load a new sequence (IDLE only); note i sits at
//   load_len                load_data[i*NOTE_W +: NOTE_W]; length clamped to DEPTH
//   play                  : start playback (level, acted on in IDLE)
//   ans_valid, ans_note   : one answered note this cycle (IDLE only)
//   busy                  : high while playing a tone/gap or echoing an answer
//   piezo_out             : note to sound, 0 = silent
//   play_done             : 1-cycle pulse when playback completes
//   ans_correct/ans_wrong : 1-cycle answer result pulses
//   round_done            : 1-cycle pulse with the last correct answer
//   ans_index             : index of the next expected note
module note_sequence_player #(
  parameter  int NOTE_W    = 4,
  parameter  int DEPTH     = 8,
  parameter  int TICKS_ON  = 5000000,
  parameter  int TICKS_OFF = 5000000,
  localparam int LEN_W     = $clog2(DEPTH + 1),
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_en,
  input  logic [NOTE_W*DEPTH-1:0] load_data,
  input  logic [LEN_W-1:0]        load_len,
  input  logic                    play,
  input  logic                    ans_valid,
  input  logic [NOTE_W-1:0]       ans_note,
  output logic                    busy,
  output logic [NOTE_W-1:0]       piezo_out,
  output logic                    play_done,
  output logic                    ans_correct,
  output logic                    ans_wrong,
  output logic                    round_done,
  output logic [IDX_W-1:0]        ans_index
);

  localparam int TMAX  = (TICKS_ON > TICKS_OFF) ? TICKS_ON : TICKS_OFF;
  localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

  localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(TICKS_ON - 1);
  localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(TICKS_OFF - 1);
  localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, TONE, GAP, ECHO} state_t;

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [NOTE_W-1:0] seq [DEPTH];
  logic [LEN_W-1:0]  length;
  logic [IDX_W-1:0]  play_idx;

  logic [IDX_W-1:0]  play_next;
  logic [LEN_W-1:0]  play_pos1;
  logic [LEN_W-1:0]  ans_pos1;
  logic [LEN_W-1:0]  len_clamped;
  logic              play_last;
  logic              ans_last;
  logic              ans_match;

  // "idx == length-1" is evaluated as "idx+1 == length" in the wider length
  // domain so that length=0 can never alias to a valid index.
  always_comb begin
    play_next   = play_idx + IDX_W'(1);
    play_pos1   = LEN_W'(play_idx) + LEN_W'(1);
    ans_pos1    = LEN_W'(ans_index) + LEN_W'(1);
    play_last   = (play_pos1 == length);
    ans_last    = (ans_pos1 == length);
    ans_match   = (length != '0) && (ans_note == seq[ans_index]);
    len_clamped = (load_len > DEPTH_L) ? DEPTH_L : load_len;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      length      <= '0;
      play_idx    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) seq[i] <= '0;
      busy        <= 1'b0;
      piezo_out   <= '0;
      play_done   <= 1'b0;
      ans_correct <= 1'b0;
      ans_wrong   <= 1'b0;
      round_done  <= 1'b0;
      ans_index   <= '0;
    end else begin
      play_done   <= 1'b0;
      ans_correct <= 1'b0;
      ans_wrong   <= 1'b0;
      round_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (load_en) begin
            for (int unsigned i = 0; i < DEPTH; i++)
              seq[i] <= load_data[i*NOTE_W +: NOTE_W];
            length    <= len_clamped;
            ans_index <= '0;
          end else if (play) begin
            if (length == '0) begin
              play_done <= 1'b1;
            end else begin
              state     <= TONE;
              timer     <= '0;
              play_idx  <= '0;
              busy      <= 1'b1;
              piezo_out <= seq[0];
              ans_index <= '0;
            end
          end else if (ans_valid) begin
            state     <= ECHO;
            timer     <= '0;
            busy      <= 1'b1;
            piezo_out <= ans_note;
            if (ans_match) begin
              ans_correct <= 1'b1;
              if (ans_last) begin
                round_done <= 1'b1;
                ans_index  <= '0;
              end else begin
                ans_index <= ans_index + IDX_W'(1);
              end
            end else begin
              ans_wrong <= 1'b1;
              ans_index <= '0;
            end
          end
        end
        TONE: begin
          if (timer == ON_LAST) begin
            state     <= GAP;
            timer     <= '0;
            piezo_out <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        GAP: begin
          if (timer == OFF_LAST) begin
            timer <= '0;
            if (play_last) begin
              state     <= IDLE;
              busy      <= 1'b0;
              play_done <= 1'b1;
            end else begin
              state     <= TONE;
              play_idx  <= play_next;
              piezo_out <= seq[play_next];
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ECHO: begin
          if (timer == ON_LAST) begin
            state     <= IDLE;
            timer     <= '0;
            busy      <= 1'b0;
            piezo_out <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          timer     <= '0;
          busy      <= 1'b0;
          piezo_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequence_player.sv
// tb_note_sequence_player
//   Self-checking bench for note_sequence_player (NOTE_W=4, DEPTH=8,
//   TICKS_ON=3, TICKS_OFF=2). A schedule-based reference model expands each
//   accepted command into the list of per-cycle outputs it must produce;
//   every cycle the DUT outputs are compared against that schedule.
module tb_note_sequence_player;

  localparam int NOTE_W = 4;
  localparam int DEPTH  = 8;
  localparam int TON    = 3;
  localparam int TOFF   = 2;
  localparam int LEN_W  = 4;
  localparam int IDX_W  = 3;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    load_en;
  logic [NOTE_W*DEPTH-1:0] load_data;
  logic [LEN_W-1:0]        load_len;
  logic                    play;
  logic                    ans_valid;
  logic [NOTE_W-1:0]       ans_note;
  logic                    busy;
  logic [NOTE_W-1:0]       piezo_out;
  logic                    play_done;
  logic                    ans_correct;
  logic                    ans_wrong;
  logic                    round_done;
  logic [IDX_W-1:0]        ans_index;

  note_sequence_player #(
    .NOTE_W   (NOTE_W),
    .DEPTH    (DEPTH),
    .TICKS_ON (TON),
    .TICKS_OFF(TOFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .load_data  (load_data),
    .load_len   (load_len),
    .play       (play),
    .ans_valid  (ans_valid),
    .ans_note   (ans_note),
    .busy       (busy),
    .piezo_out  (piezo_out),
    .play_done  (play_done),
    .ans_correct(ans_correct),
    .ans_wrong  (ans_wrong),
    .round_done (round_done),
    .ans_index  (ans_index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Output vector: {busy, piezo[3:0], play_done, ans_correct, ans_wrong, round_done, ans_index[2:0]}
  int          m_seq [DEPTH];
  int          m_len = 0;
  int          m_idx = 0;
  logic [11:0] sched [$];
  logic        m_busy = 1'b0;
  logic [11:0] exp_v, act_v;
  bit          ok, last;

  function automatic logic [11:0] pk(int b, int p, int d, int c, int w, int r, int x);
    return {1'(b), 4'(p), 1'(d), 1'(c), 1'(w), 1'(r), 3'(x)};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_len = 0;
      m_idx = 0;
      for (int n = 0; n < DEPTH; n++) m_seq[n] = 0;
      sched.delete();
      m_busy = 1'b0;
    end else if (sched.size() == 0 && !m_busy) begin
      if (load_en) begin
        for (int n = 0; n < DEPTH; n++) m_seq[n] = int'(load_data[n*NOTE_W +: NOTE_W]);
        m_len = (int'(load_len) > DEPTH) ? DEPTH : int'(load_len);
        m_idx = 0;
      end else if (play) begin
        if (m_len == 0) begin
          sched.push_back(pk(0, 0, 1, 0, 0, 0, m_idx));
        end else begin
          m_idx = 0;
          for (int n = 0; n < m_len; n++) begin
            repeat (TON)  sched.push_back(pk(1, m_seq[n], 0, 0, 0, 0, 0));
            repeat (TOFF) sched.push_back(pk(1, 0, 0, 0, 0, 0, 0));
          end
          sched.push_back(pk(0, 0, 1, 0, 0, 0, 0));
        end
      end else if (ans_valid) begin
        ok   = (m_len > 0) && (int'(ans_note) == m_seq[m_idx]);
        last = ok && (m_idx == m_len - 1);
        if (ok && !last) m_idx = m_idx + 1;
        else             m_idx = 0;
        sched.push_back(pk(1, int'(ans_note), 0, ok, !ok, last, m_idx));
        repeat (TON - 1) sched.push_back(pk(1, int'(ans_note), 0, 0, 0, 0, m_idx));
      end
    end
    exp_v  = (sched.size() != 0) ? sched.pop_front() : pk(0, 0, 0, 0, 0, 0, m_idx);
    m_busy = exp_v[11];
    #1;
    act_v = {busy, piezo_out, play_done, ans_correct, ans_wrong, round_done, ans_index};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_compare t=%0t {busy,piezo,done,ok,wrong,round,idx} actual=%b_%h_%b%b%b%b_%0d required=%b_%h_%b%b%b%b_%0d",
               $time, act_v[11], act_v[10:7], act_v[6], act_v[5], act_v[4], act_v[3], act_v[2:0],
               exp_v[11], exp_v[10:7], exp_v[6], exp_v[5], exp_v[4], exp_v[3], exp_v[2:0]);
    end
  end

  // ---------------- stimulus + literal checks ----------------
  int exp_p [15] = '{1, 1, 1, 0, 0, 2, 2, 2, 0, 0, 3, 3, 3, 0, 0};
  int nb, nd, np, ne;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply(input logic le, input logic [31:0] d, input logic [3:0] l,
                       input logic pl, input logic av, input logic [3:0] an);
    load_en   = le;
    load_data = d;
    load_len  = l;
    play      = pl;
    ans_valid = av;
    ans_note  = an;
    cyc();
    load_en   = 1'b0;
    play      = 1'b0;
    ans_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; load_data = '0; load_len = '0;
    play = 1'b0; ans_valid = 1'b0; ans_note = '0;
    cyc(3);
    reset = 1'b0;
    cyc();
    chk("reset_busy", int'(busy), 0);
    chk("reset_piezo", int'(piezo_out), 0);
    chk("reset_ans_index", int'(ans_index), 0);

    // playback of {1,2,3}
    apply(1'b1, 32'h0000_0321, 4'd3, 1'b0, 1'b0, 4'd0);
    apply(1'b0, '0, '0, 1'b1, 1'b0, 4'd0);
    nb = 0; nd = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 15) chk($sformatf("play_piezo_%0d", i), int'(piezo_out), exp_p[i]);
      if (i == 15) chk("play_done_pulse", int'(play_done), 1);
      nb += int'(busy); nd += int'(play_done);
      cyc();
    end
    chk("play_busy_cycles", nb, 15);
    chk("play_done_count", nd, 1);

    // length clamp: 12 -> 8 notes, 8*(3+2) busy cycles
    apply(1'b1, $urandom, 4'd12, 1'b0, 1'b0, 4'd0);
    apply(1'b0, '0, '0, 1'b1, 1'b0, 4'd0);
    nb = 0;
    for (int i = 0; i < 45; i++) begin nb += int'(busy); cyc(); end
    chk("clamp_busy_cycles", nb, 40);

    // load and play together: load wins
    apply(1'b1, 32'h0000_0321, 4'd3, 1'b1, 1'b0, 4'd0);
    nb = 0; nd = 0;
    for (int i = 0; i < 6; i++) begin nb += int'(busy); nd += int'(play_done); cyc(); end
    chk("loadplay_busy", nb, 0);
    chk("loadplay_done", nd, 0);

    // correct answers 1,2,3
    chk("ans_idx_start", int'(ans_index), 0);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, '0, '0, 1'b0, 1'b1, 4'(k + 1));
      chk($sformatf("ans_correct_%0d", k), int'(ans_correct), 1);
      chk($sformatf("ans_round_%0d", k), int'(round_done), (k == 2) ? 1 : 0);
      chk($sformatf("ans_index_%0d", k), int'(ans_index), (k + 1) % 3);
      ne = 0;
      for (int j = 0; j < 3; j++) begin ne += (int'(piezo_out) == k + 1) ? 1 : 0; cyc(); end
      chk($sformatf("echo_len_%0d", k), ne, 3);
    end

    // wrong answer after a correct one
    apply(1'b0, '0, '0, 1'b0, 1'b1, 4'd1);
    chk("wrong_first_ok", int'(ans_correct), 1);
    cyc(3);
    apply(1'b0, '0, '0, 1'b0, 1'b1, 4'd5);
    chk("wrong_pulse", int'(ans_wrong), 1);
    chk("wrong_index", int'(ans_index), 0);
    cyc(3);

    // inputs during playback are dropped
    apply(1'b0, '0, '0, 1'b1, 1'b0, 4'd0);
    nb = 0; np = 0;
    for (int i = 0; i < 20; i++) begin
      ans_valid = (i == 1 || i == 6); play = (i == 3); ans_note = 4'd1;
      nb += int'(busy); np += int'(ans_correct | ans_wrong);
      cyc();
    end
    ans_valid = 1'b0; play = 1'b0;
    chk("ignore_play_busy", nb, 15);
    chk("ignore_play_pulses", np, 0);

    // answers during ECHO (including its exit cycle) are dropped
    apply(1'b0, '0, '0, 1'b0, 1'b1, 4'd1);
    np = 0;
    for (int j = 0; j < 3; j++) begin
      ans_valid = 1'b1; ans_note = 4'd2;
      cyc();
      np += int'(ans_correct | ans_wrong);
    end
    ans_valid = 1'b0;
    cyc(2);
    chk("ignore_echo_pulses", np, 0);
    chk("ignore_echo_index", int'(ans_index), 1);

    // reset in the second TONE cycle
    apply(1'b0, '0, '0, 1'b1, 1'b0, 4'd0);
    cyc();
    reset = 1'b1;
    #1;
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_piezo", int'(piezo_out), 0);
    cyc();
    reset = 1'b0;
    apply(1'b0, '0, '0, 1'b1, 1'b0, 4'd0);
    chk("postreset_done", int'(play_done), 1);
    chk("postreset_busy", int'(busy), 0);
    cyc();
    chk("postreset_done_end", int'(play_done), 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      load_en   = ($urandom_range(0, 99) < 6);
      for (int n = 0; n < DEPTH; n++) load_data[n*NOTE_W +: NOTE_W] = 4'($urandom_range(0, 3));
      load_len  = 4'($urandom_range(0, 12));
      play      = ($urandom_range(0, 99) < 5);
      ans_valid = ($urandom_range(0, 99) < 30);
      ans_note  = $urandom_range(0, 1) ? 4'(m_seq[m_idx]) : 4'($urandom_range(0, 3));
      cyc();
    end
    reset = 1'b0; load_en = 1'b0; play = 1'b0; ans_valid = 1'b0;
    cyc(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
